// File: rtl/mem_1r1w_sync.sv
`default_nettype none
// ============================================================================
//  Module      : mem_1r1w_sync
//  Description : Single-clock register-array RAM with one write port and one
//                registered read port (1-cycle read latency). Out-of-range
//                writes are dropped and out-of-range reads return zero. The
//                same-address collision policy is selectable: old data or
//                write-through.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_1r1w_sync #(
  parameter  int width_p                = 32,
  parameter  int els_p                  = 16,
  parameter  int harden_p               = 1,
  parameter  int read_write_same_addr_p = 0,
  localparam int addr_width_lp          = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  // Highest legal address, expressed in the address width for comparisons.
  localparam logic [addr_width_lp-1:0] c_last_addr     = addr_width_lp'(els_p - 1);
  // Collision policy: when set, a same-address read sees the word being written.
  localparam bit                       c_write_through = (read_write_same_addr_p != 0);

  // Storage array; locations are deliberately left uninitialised.
  logic [width_p-1:0] r_mem [els_p];
  logic [width_p-1:0] r_data;

  logic w_wr_in_range;
  logic w_rd_in_range;
  logic w_wr_en;
  logic w_collision;

  // Address range qualification. When els_p fills the whole address space
  // every address is legal, so the comparison collapses to a constant.
  generate
    if ((2 ** addr_width_lp) > els_p) begin : g_range_check
      assign w_wr_in_range = (w_addr_i <= c_last_addr);
      assign w_rd_in_range = (r_addr_i <= c_last_addr);
    end else begin : g_full_range
      assign w_wr_in_range = 1'b1;
      assign w_rd_in_range = 1'b1;
    end
  endgenerate

  // A write commits only outside reset and to a legal address.
  assign w_wr_en     = w_v_i && w_wr_in_range && !reset_i;
  // Same-cycle write to the address being read (both legal).
  assign w_collision = w_wr_en && (w_addr_i == r_addr_i);

  // Array update; contents are intentionally not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[w_addr_i] <= w_data_i;
    end
  end

  // Registered read port: cleared by reset, loads on r_v_i, otherwise holds.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_data <= '0;
    end else if (r_v_i) begin
      if (!w_rd_in_range) begin
        r_data <= '0;
      end else if (c_write_through && w_collision) begin
        r_data <= w_data_i;
      end else begin
        r_data <= r_mem[r_addr_i];
      end
    end
  end

  assign r_data_o = r_data;

`ifndef SYNTHESIS
  logic r_params_shown;

  // Simulation-only diagnostics: parameter banner once, then access checks.
  always_ff @(posedge clk_i) begin
    if (r_params_shown !== 1'b1) begin
      $info("mem_1r1w_sync: width_p=%0d els_p=%0d harden_p=%0d",
            width_p, els_p, harden_p);
    end
    r_params_shown <= 1'b1;
    if (!reset_i) begin
      if (w_v_i && !w_wr_in_range) begin
        $warning("mem_1r1w_sync error: write address %0d out of range (els_p=%0d)",
                 w_addr_i, els_p);
      end
      if (r_v_i && !w_rd_in_range) begin
        $warning("mem_1r1w_sync error: read address %0d out of range (els_p=%0d)",
                 r_addr_i, els_p);
      end
      if (!c_write_through && r_v_i && w_collision) begin
        $warning("mem_1r1w_sync: same-address read/write at %0d returns old data",
                 r_addr_i);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_1r1w_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_1r1w_sync
//  Description : Self-checking bench for mem_1r1w_sync. Instance A uses the
//                old-data collision policy, instance B (same stimulus) uses
//                write-through, instance C has els_p=12, instance D has
//                els_p=1 and width_p=1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_1r1w_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Shared stimulus for A and B
  logic        w_v = 1'b0;
  logic [3:0]  w_addr = '0;
  logic [31:0] w_data = '0;
  logic        r_v = 1'b0;
  logic [3:0]  r_addr = '0;
  logic [31:0] a_r_data;
  logic [31:0] b_r_data;

  // Instance C (els_p=12)
  logic        c_w_v = 1'b0;
  logic [3:0]  c_w_addr = '0;
  logic [31:0] c_w_data = '0;
  logic        c_r_v = 1'b0;
  logic [3:0]  c_r_addr = '0;
  logic [31:0] c_r_data;

  // Instance D (els_p=1, width_p=1)
  logic        d_w_v = 1'b0;
  logic [0:0]  d_w_addr = '0;
  logic [0:0]  d_w_data = '0;
  logic        d_r_v = 1'b0;
  logic [0:0]  d_r_addr = '0;
  logic [0:0]  d_r_data;

  mem_1r1w_sync #(.width_p(32), .els_p(16), .harden_p(1), .read_write_same_addr_p(0)) u_a (
    .clk_i(clk), .reset_i(rst), .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data),
    .r_v_i(r_v), .r_addr_i(r_addr), .r_data_o(a_r_data));

  mem_1r1w_sync #(.width_p(32), .els_p(16), .harden_p(0), .read_write_same_addr_p(1)) u_b (
    .clk_i(clk), .reset_i(rst), .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data),
    .r_v_i(r_v), .r_addr_i(r_addr), .r_data_o(b_r_data));

  mem_1r1w_sync #(.width_p(32), .els_p(12), .harden_p(1), .read_write_same_addr_p(0)) u_c (
    .clk_i(clk), .reset_i(rst), .w_v_i(c_w_v), .w_addr_i(c_w_addr), .w_data_i(c_w_data),
    .r_v_i(c_r_v), .r_addr_i(c_r_addr), .r_data_o(c_r_data));

  mem_1r1w_sync #(.width_p(1), .els_p(1), .harden_p(1), .read_write_same_addr_p(0)) u_d (
    .clk_i(clk), .reset_i(rst), .w_v_i(d_w_v), .w_addr_i(d_w_addr), .w_data_i(d_w_data),
    .r_v_i(d_r_v), .r_addr_i(d_r_addr), .r_data_o(d_r_data));

  // Reference contents for A/B (both see identical writes)
  logic [31:0] model [16];

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    w_v = 1'b1; w_addr = 4'd3; w_data = 32'hDEADBEEF;
    r_v = 1'b1; r_addr = 4'd3;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (a_r_data !== 32'h0) begin
        errors++; $display("FAIL reset_a cycle %0d: got %h expected %h", i, a_r_data, 32'h0);
      end
      checks++;
      if (b_r_data !== 32'h0) begin
        errors++; $display("FAIL reset_b cycle %0d: got %h expected %h", i, b_r_data, 32'h0);
      end
    end
    checks++;
    if (c_r_data !== 32'h0) begin
      errors++; $display("FAIL reset_c: got %h expected %h", c_r_data, 32'h0);
    end
    checks++;
    if (d_r_data !== 1'b0) begin
      errors++; $display("FAIL reset_d: got %h expected %h", d_r_data, 1'b0);
    end
    rst = 1'b0;
    w_v = 1'b0;
    r_v = 1'b1; r_addr = 4'd3;
    step();
    checks++;
    if (a_r_data === 32'hDEADBEEF) begin
      errors++; $display("FAIL reset_write_ignored: got %h expected anything but %h", a_r_data, 32'hDEADBEEF);
    end
    r_v = 1'b0;
  endtask

  task automatic test_basic_rw();
    w_v = 1'b1; w_addr = 4'd0;  w_data = 32'h11111111; step(); model[0]  = 32'h11111111;
    w_v = 1'b1; w_addr = 4'd15; w_data = 32'hA5A5A5A5; step(); model[15] = 32'hA5A5A5A5;
    w_v = 1'b0;
    r_v = 1'b1; r_addr = 4'd15;
    step();
    checks++;
    if (a_r_data !== model[15]) begin
      errors++; $display("FAIL basic_read15: got %h expected %h", a_r_data, model[15]);
    end
    r_addr = 4'd0;
    step();
    checks++;
    if (a_r_data !== model[0]) begin
      errors++; $display("FAIL basic_read0: got %h expected %h", a_r_data, model[0]);
    end
    r_v = 1'b0;
  endtask

  task automatic test_hold();
    r_v = 1'b1; r_addr = 4'd0;
    step();
    checks++;
    if (a_r_data !== 32'h11111111) begin
      errors++; $display("FAIL hold_first_read: got %h expected %h", a_r_data, 32'h11111111);
    end
    r_v = 1'b0;
    w_v = 1'b1; w_addr = 4'd0; w_data = 32'h22222222; model[0] = 32'h22222222;
    step();
    w_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (a_r_data !== 32'h11111111) begin
        errors++; $display("FAIL hold_idle %0d: got %h expected %h", i, a_r_data, 32'h11111111);
      end
      step();
    end
    r_v = 1'b1; r_addr = 4'd0;
    step();
    checks++;
    if (a_r_data !== 32'h22222222) begin
      errors++; $display("FAIL hold_reread: got %h expected %h", a_r_data, 32'h22222222);
    end
    r_v = 1'b0;
  endtask

  task automatic test_collision();
    w_v = 1'b1; w_addr = 4'd5; w_data = 32'h5; step(); model[5] = 32'h5;
    w_data = 32'h6; r_v = 1'b1; r_addr = 4'd5;
    step();
    model[5] = 32'h6;
    checks++;
    if (a_r_data !== 32'h5) begin
      errors++; $display("FAIL collision_old_data: got %h expected %h", a_r_data, 32'h5);
    end
    checks++;
    if (b_r_data !== 32'h6) begin
      errors++; $display("FAIL collision_write_through: got %h expected %h", b_r_data, 32'h6);
    end
    w_v = 1'b0;
    step();
    checks++;
    if (a_r_data !== 32'h6) begin
      errors++; $display("FAIL collision_next_a: got %h expected %h", a_r_data, 32'h6);
    end
    checks++;
    if (b_r_data !== 32'h6) begin
      errors++; $display("FAIL collision_next_b: got %h expected %h", b_r_data, 32'h6);
    end
    r_v = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        wv, rv;
    logic [3:0]  wa, ra;
    logic [31:0] wd;
    r_v = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w_v = 1'b1; w_addr = 4'(i); w_data = $urandom; model[i] = w_data;
      step();
    end
    exp_a = a_r_data;
    exp_b = b_r_data;
    for (int n = 0; n < 300; n++) begin
      wv = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      wd = $urandom;
      if (rv) begin
        exp_a = model[ra];
        exp_b = (wv && wa == ra) ? wd : model[ra];
      end
      if (wv) model[wa] = wd;
      w_v = wv; w_addr = wa; w_data = wd; r_v = rv; r_addr = ra;
      step();
      checks++;
      if (a_r_data !== exp_a) begin
        errors++; $display("FAIL random_a iter %0d: got %h expected %h", n, a_r_data, exp_a);
      end
      checks++;
      if (b_r_data !== exp_b) begin
        errors++; $display("FAIL random_b iter %0d: got %h expected %h", n, b_r_data, exp_b);
      end
    end
    w_v = 1'b0; r_v = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic [31:0] cmodel [12];
    for (int i = 0; i < 12; i++) begin
      c_w_v = 1'b1; c_w_addr = 4'(i); c_w_data = 32'h100 + 32'(i); cmodel[i] = c_w_data;
      step();
    end
    c_w_v = 1'b1; c_w_addr = 4'd13; c_w_data = 32'h77;
    step();
    c_w_v = 1'b0;
    for (int i = 0; i < 12; i++) begin
      c_r_v = 1'b1; c_r_addr = 4'(i);
      step();
      checks++;
      if (c_r_data !== cmodel[i]) begin
        errors++; $display("FAIL oor_array_intact addr %0d: got %h expected %h", i, c_r_data, cmodel[i]);
      end
    end
    c_r_addr = 4'd13;
    step();
    checks++;
    if (c_r_data !== 32'h0) begin
      errors++; $display("FAIL oor_read13: got %h expected %h", c_r_data, 32'h0);
    end
    c_r_addr = 4'd1; step();
    c_r_addr = 4'd12;
    step();
    checks++;
    if (c_r_data !== 32'h0) begin
      errors++; $display("FAIL oor_read12: got %h expected %h", c_r_data, 32'h0);
    end
    c_r_v = 1'b0;
  endtask

  task automatic test_tiny();
    d_w_v = 1'b1; d_w_addr = 1'b0; d_w_data = 1'b1; step();
    d_w_v = 1'b0; d_r_v = 1'b1; d_r_addr = 1'b0;
    step();
    checks++;
    if (d_r_data !== 1'b1) begin
      errors++; $display("FAIL tiny_read_one: got %h expected %h", d_r_data, 1'b1);
    end
    d_r_v = 1'b0;
    d_w_v = 1'b1; d_w_addr = 1'b1; d_w_data = 1'b0; step();
    d_w_v = 1'b0; d_r_v = 1'b1; d_r_addr = 1'b0;
    step();
    checks++;
    if (d_r_data !== 1'b1) begin
      errors++; $display("FAIL tiny_oor_write_dropped: got %h expected %h", d_r_data, 1'b1);
    end
    d_r_addr = 1'b1;
    step();
    checks++;
    if (d_r_data !== 1'b0) begin
      errors++; $display("FAIL tiny_oor_read: got %h expected %h", d_r_data, 1'b0);
    end
    d_w_v = 1'b1; d_w_addr = 1'b0; d_w_data = 1'b0; d_r_v = 1'b0; step();
    d_w_v = 1'b0; d_r_v = 1'b1; d_r_addr = 1'b0; step(); step();
    d_w_v = 1'b1; d_w_data = 1'b1; d_r_v = 1'b0; step();
    d_w_v = 1'b0; d_r_v = 1'b1; d_r_addr = 1'b0;
    step();
    checks++;
    if (d_r_data !== 1'b1) begin
      errors++; $display("FAIL tiny_rewrite: got %h expected %h", d_r_data, 1'b1);
    end
    d_r_v = 1'b0;
  endtask

  initial begin
    step();
    test_reset();
    test_basic_rw();
    test_hold();
    test_collision();
    test_random();
    test_out_of_range();
    test_tiny();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
